dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitration and sequencing controller for the single-port 4 KB data memory. It shares one memory port between two requesters: the pipeline load/store port (P) and the DMA/debug port (D). Requests are granted round-robin, each access is sequenced through a fixed-latency FSM, and a stall is raised to the pipeline while its access is pending. It sits between the MEM stage and the data memory array, which has a synchronous 1-cycle read.

Parameters:
DATA_W, 32, data width of memory words and both requester data buses
ADDR_W, 10, memory word-index width; depth = 2^ADDR_W words

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high
p_req  input  1  pipeline request; held until p_ack
p_we  input  1  pipeline write (1) / read (0)
p_addr  input  32  pipeline byte address
p_wdata  input  DATA_W  pipeline write data
p_rdata  output  DATA_W  pipeline read data; valid with p_ack
p_ack  output  1  one-cycle completion pulse to pipeline
p_err  output  1  error flag; valid with p_ack
p_stall  output  1  pipeline stall
d_req, d_we, d_addr, d_wdata  input  1/1/32/DATA_W  DMA request; same meaning as the P signals
d_rdata, d_ack, d_err  output  DATA_W/1/1  DMA response; same meaning as the P signals
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory word index
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid 1 cycle after mem_en with mem_we=0

Behaviour:
- Reset values: FSM=IDLE, last_grant=D (so P wins the first tie), p_rdata=d_rdata=0, all ack/err=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-access: return to IDLE at once. No ack is issued and no memory write occurs after reset asserts.
- FSM states: IDLE, SERVE, RDATA, DONE.
- IDLE, arbitration:
  - If exactly one request is present, grant it.
  - If both are present, grant the requester that is not last_grant.
  - Latch the owner, we, addr and wdata, update last_grant, and go to SERVE.
  - If no request is present, stay in IDLE.
- Address check, applied at latch time:
  - Error if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
  - Otherwise the word index is addr[ADDR_W+1:2].
- SERVE:
  - If error: no memory access; go to DONE with err=1 and rdata=0.
  - Write: mem_en=1, mem_we=1, mem_addr and mem_wdata from the latch; go to DONE.
  - Read: mem_en=1, mem_we=0; go to RDATA.
- RDATA: capture mem_rdata into the owner's rdata register at the clock edge; go to DONE.
- DONE: assert the owner's ack for exactly 1 cycle, with err as latched; return to IDLE.
- rdata retention: the owner's rdata holds until that owner's next read completes. After a write or error response, rdata=0.
- Latency from the first cycle req is seen in IDLE to the ack cycle: write 2 cycles, read 3 cycles, error 2 cycles. Minimum issue interval per access is 3 cycles (write) or 4 cycles (read).
- Memory side: mem_en is high only in SERVE when there is no error. mem_addr and mem_wdata are stable only in that cycle.
- p_stall = p_req & ~p_ack, driven combinationally. It is held high while P waits on a DMA access.
- Requester rules:
  - Hold req, we, addr and wdata constant until ack.
  - Req may drop in the cycle after ack, or stay high for a new access. The FSM is in IDLE then, so back-to-back requests are legal.
  - Changing inputs before ack is a protocol violation; the latched values are used.
- Fairness: with both requesters continuously requesting, grants alternate P, D, P, D.

Test Plan:
1. Reset, then P write 0xDEADBEEF at 0x10 -> mem_en=mem_we=1 with mem_addr=4 in cycle 1, p_ack in cycle 2, p_stall high cycles 0–1.
2. P read 0x10, with the memory model returning 0xDEADBEEF -> mem_en=1, mem_we=0 in cycle 1; p_ack with p_rdata=0xDEADBEEF in cycle 3, p_err=0.
3. P and D request in the same cycle right after reset -> P granted first, D granted next; continued contention gives grant order P, D, P, D; p_stall high throughout D's service.
4. P read at 0x13 (misaligned) and D write at 0x1000 (out of range) -> each acks with err=1 and rdata=0; mem_en never asserts.
5. Assert reset during RDATA of a D read -> d_ack never pulses, FSM returns to IDLE, outputs return to reset values, and the next P write completes normally.
6. P holds p_req across its ack and issues 4 back-to-back writes -> acks at cycles 2, 5, 8, 11 with correct mem_addr each time.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer that shares the single-port data memory
// between the pipeline (P) and the DMA/debug (D) requesters.
//
// state | meaning
// IDLE  | arbitrate; latch winner's request and drive the memory port for SERVE
// SERVE | memory access cycle (suppressed on address error)
// RDATA | memory read data valid; capture into owner's rdata
// DONE  | owner's ack/err pulse
module dmem_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [31:0]       p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic [DATA_W-1:0] p_rdata,
   output logic              p_ack,
   output logic              p_err,
   output logic              p_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE, RDATA, DONE} state_t;

   state_t              state;
   logic                last_d;
   logic                own_d;
   logic                lat_we;
   logic                lat_err;

   logic                grant_d;
   logic                sel_we;
   logic                sel_err;
   logic [31:0]         sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [ADDR_W-1:0]   sel_idx;

   // On a tie the requester that did not win last time is served.
   always_comb begin
      grant_d   = d_req & (~p_req | ~last_d);
      sel_we    = grant_d ? d_we    : p_we;
      sel_addr  = grant_d ? d_addr  : p_addr;
      sel_wdata = grant_d ? d_wdata : p_wdata;
      sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
      sel_idx   = sel_addr[ADDR_W+1:2];
   end

   assign p_stall = p_req & ~p_ack;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         last_d    <= 1'b1;
         own_d     <= 1'b0;
         lat_we    <= 1'b0;
         lat_err   <= 1'b0;
         p_rdata   <= '0;
         d_rdata   <= '0;
         p_ack     <= 1'b0;
         d_ack     <= 1'b0;
         p_err     <= 1'b0;
         d_err     <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         p_ack <= 1'b0;
         d_ack <= 1'b0;
         p_err <= 1'b0;
         d_err <= 1'b0;
         case (state)
            IDLE: begin
               if (p_req || d_req) begin
                  own_d   <= grant_d;
                  last_d  <= grant_d;
                  lat_we  <= sel_we;
                  lat_err <= sel_err;
                  // Memory port is registered here so it is live exactly in SERVE.
                  if (!sel_err) begin
                     mem_en    <= 1'b1;
                     mem_we    <= sel_we;
                     mem_addr  <= sel_idx;
                     mem_wdata <= sel_wdata;
                  end
                  state <= SERVE;
               end
            end
            SERVE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               if (lat_err || lat_we) begin
                  if (own_d) begin
                     d_ack   <= 1'b1;
                     d_err   <= lat_err;
                     d_rdata <= '0;
                  end else begin
                     p_ack   <= 1'b1;
                     p_err   <= lat_err;
                     p_rdata <= '0;
                  end
                  state <= DONE;
               end else begin
                  state <= RDATA;
               end
            end
            RDATA: begin
               if (own_d) begin
                  d_ack   <= 1'b1;
                  d_rdata <= mem_rdata;
               end else begin
                  p_ack   <= 1'b1;
                  p_rdata <= mem_rdata;
               end
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized request mixes, checked
// cycle by cycle against a schedule predicted from the arbitration and latency rules.
module tb_dmem_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int NC     = 256;

   logic              clk = 1'b0;
   logic              reset;
   logic              p_req, p_we, d_req, d_we;
   logic [31:0]       p_addr, d_addr;
   logic [DATA_W-1:0] p_wdata, d_wdata, p_rdata, d_rdata;
   logic              p_ack, p_err, p_stall, d_ack, d_err;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_rdata(p_rdata), .p_ack(p_ack), .p_err(p_err), .p_stall(p_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Data memory array with synchronous 1-cycle read.
   logic [31:0] mem_arr [1024];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem_arr[mem_addr] = mem_wdata;
         else        mem_rdata <= mem_arr[mem_addr];
      end
   end

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   acc_t        qp[$];
   acc_t        qd[$];
   logic [31:0] ref_mem [1024];

   bit          e_pack[NC], e_dack[NC], e_perr[NC], e_derr[NC], e_men[NC], e_mwe[NC];
   logic [31:0] e_prd[NC], e_drd[NC], e_mwd[NC], e_madr[NC];
   int          last_cycle;
   logic [31:0] mdl_prd, mdl_drd;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit to_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      acc_t a;
      a.we = we; a.addr = addr; a.wdata = wdata;
      if (to_d) qd.push_back(a);
      else      qp.push_back(a);
   endtask

   task automatic check_reset_state(input string name);
      chk({name, " rst p_rdata"}, p_rdata, 32'h0);
      chk({name, " rst d_rdata"}, d_rdata, 32'h0);
      chk({name, " rst acks"}, {30'b0, p_ack, d_ack}, 32'h0);
      chk({name, " rst errs"}, {30'b0, p_err, d_err}, 32'h0);
      chk({name, " rst mem_en_we"}, {30'b0, mem_en, mem_we}, 32'h0);
      chk({name, " rst mem_addr"}, 32'(mem_addr), 32'h0);
      chk({name, " rst mem_wdata"}, mem_wdata, 32'h0);
   endtask

   task automatic idle_inputs();
      p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state(name);
      reset   = 1'b0;
      mdl_prd = 0;
      mdl_drd = 0;
   endtask

   // Predict the whole timeline: every access starts when the FSM is idle and both
   // queues present their head request continuously, so grants follow alternation.
   task automatic build_schedule();
      int  ip = 0;
      int  id = 0;
      int  t  = 0;
      bit  last_d = 1'b1;
      for (int c = 0; c < NC; c++) begin
         e_pack[c] = 0; e_dack[c] = 0; e_perr[c] = 0; e_derr[c] = 0;
         e_men[c] = 0; e_mwe[c] = 0; e_prd[c] = 0; e_drd[c] = 0;
         e_mwd[c] = 0; e_madr[c] = 0;
      end
      while (ip < qp.size() || id < qd.size()) begin
         bit          pw, dw, gd, err;
         acc_t        a;
         int          idx, ack;
         logic [31:0] rd;
         pw = ip < qp.size();
         dw = id < qd.size();
         gd = dw && (!pw || !last_d);
         if (gd) begin a = qd[id]; id++; end
         else    begin a = qp[ip]; ip++; end
         err = (a.addr % 4 != 0) || (a.addr >= 4096);
         idx = int'(a.addr / 4);
         ack = t + ((a.we || err) ? 2 : 3);
         rd  = 0;
         if (!err) begin
            e_men[t+1]  = 1;
            e_mwe[t+1]  = a.we;
            e_madr[t+1] = 32'(idx);
            e_mwd[t+1]  = a.wdata;
            if (a.we) ref_mem[idx] = a.wdata;
            else      rd = ref_mem[idx];
         end
         if (gd) begin e_dack[ack] = 1; e_derr[ack] = err; e_drd[ack] = rd; end
         else    begin e_pack[ack] = 1; e_perr[ack] = err; e_prd[ack] = rd; end
         last_d = gd;
         t = ack + 1;
      end
      last_cycle = t + 2;
   endtask

   task automatic drive_p(input int i);
      if (i < qp.size()) begin
         p_req = 1; p_we = qp[i].we; p_addr = qp[i].addr; p_wdata = qp[i].wdata;
      end else begin
         p_req = 0; p_we = 0; p_addr = 0; p_wdata = 0;
      end
   endtask

   task automatic drive_d(input int i);
      if (i < qd.size()) begin
         d_req = 1; d_we = qd[i].we; d_addr = qd[i].addr; d_wdata = qd[i].wdata;
      end else begin
         d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      end
   endtask

   task automatic run(input string name, input bit apply_reset);
      int ip = 0;
      int id = 0;
      build_schedule();
      if (apply_reset) do_reset(name);
      drive_p(0);
      drive_d(0);
      #1;
      chk({name, " stall c0"}, 32'(p_stall), 32'(qp.size() > 0));
      for (int c = 1; c <= last_cycle; c++) begin
         string tg;
         @(posedge clk);
         #1;
         tg = $sformatf("%s c%0d", name, c);
         chk({tg, " p_ack"}, 32'(p_ack), 32'(e_pack[c]));
         chk({tg, " d_ack"}, 32'(d_ack), 32'(e_dack[c]));
         chk({tg, " p_stall"}, 32'(p_stall), 32'(ip < qp.size() && !e_pack[c]));
         if (e_pack[c]) begin
            chk({tg, " p_err"}, 32'(p_err), 32'(e_perr[c]));
            mdl_prd = e_prd[c];
         end
         if (e_dack[c]) begin
            chk({tg, " d_err"}, 32'(d_err), 32'(e_derr[c]));
            mdl_drd = e_drd[c];
         end
         chk({tg, " p_rdata"}, p_rdata, mdl_prd);
         chk({tg, " d_rdata"}, d_rdata, mdl_drd);
         chk({tg, " mem_en"}, 32'(mem_en), 32'(e_men[c]));
         if (e_men[c]) begin
            chk({tg, " mem_we"}, 32'(mem_we), 32'(e_mwe[c]));
            chk({tg, " mem_addr"}, 32'(mem_addr), e_madr[c]);
            if (e_mwe[c]) chk({tg, " mem_wdata"}, mem_wdata, e_mwd[c]);
         end
         if (e_pack[c]) begin ip++; drive_p(ip); end
         if (e_dack[c]) begin id++; drive_d(id); end
      end
      qp.delete();
      qd.delete();
   endtask

   function automatic logic [31:0] rand_addr();
      int r, idx;
      r   = int'($urandom_range(0, 9));
      idx = (r == 2) ? 1023 : int'($urandom_range(0, 15));
      if (r == 0) return 32'(idx * 4 + int'($urandom_range(1, 3)));
      if (r == 1) return {20'($urandom_range(1, 32'hFFFFF)), 12'(idx * 4)};
      return 32'(idx * 4);
   endfunction

   initial begin
      mem_rdata = 0;
      for (int i = 0; i < 1024; i++) begin
         mem_arr[i] = $urandom;
         ref_mem[i] = mem_arr[i];
      end
      idle_inputs();
      reset = 1'b1;

      push(0, 1, 32'h10, 32'hDEADBEEF);
      run("t1_write", 1);

      push(0, 0, 32'h10, 32'h0);
      run("t2_read", 1);

      push(0, 1, 32'h20, 32'h11112222);
      push(0, 0, 32'h20, 32'h0);
      push(0, 1, 32'h24, 32'h33334444);
      push(1, 0, 32'h10, 32'h0);
      push(1, 1, 32'h28, 32'h55556666);
      push(1, 0, 32'h24, 32'h0);
      run("t3_contend", 1);

      push(0, 0, 32'h13, 32'h0);
      push(1, 1, 32'h1000, 32'hCAFEF00D);
      run("t4_errors", 1);

      // Reset lands while a D read sits in RDATA.
      do_reset("t5_pre");
      d_req = 1; d_we = 0; d_addr = 32'h20; d_wdata = 0;
      @(posedge clk); #1;
      chk("t5 mem_en serve", 32'(mem_en), 32'h1);
      @(posedge clk); #1;
      reset = 1'b1;
      idle_inputs();
      #1;
      check_reset_state("t5_mid");
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk($sformatf("t5 hold%0d d_ack", c), 32'(d_ack), 32'h0);
         chk($sformatf("t5 hold%0d mem_en", c), 32'(mem_en), 32'h0);
      end
      reset   = 1'b0;
      mdl_prd = 0;
      mdl_drd = 0;
      push(0, 1, 32'h30, 32'h0BADCAFE);
      run("t5_after", 0);

      for (int i = 0; i < 4; i++) push(0, 1, 32'(32'h40 + 4 * i), $urandom);
      run("t6_b2b", 1);

      for (int r = 0; r < 8; r++) begin
         int np, nd;
         np = int'($urandom_range(0, 5));
         nd = int'($urandom_range(1, 5));
         for (int i = 0; i < np; i++) push(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         for (int i = 0; i < nd; i++) push(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         run($sformatf("rnd%0d", r), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
